// File: rtl/dtc_therm_decode_stage.sv
// Thermometer-code decode stage: legality check, popcount level, 2-entry output buffer, saturating stats.
// Optional per-level histogram bins are built when DTC_THERM_HIST_EN is defined.
module dtc_therm_decode_stage #(
    parameter int CODE_W = 8,
    parameter int CNT_W  = 16,
    localparam int LVL_W = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  out_level,
    output logic              out_err,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  total_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic [LVL_W-1:0]  hist_sel,
    output logic [CNT_W-1:0]  hist_cnt
);

    logic [LVL_W-1:0]  dec_level;
    logic [CODE_W-1:0] therm_mask;
    logic              dec_err;

    logic [LVL_W-1:0]  head_level_reg, tail_level_reg;
    logic              head_err_reg, tail_err_reg;
    logic [1:0]        occ_reg, occ_next;
    logic              in_ready_reg, out_valid_reg;
    logic [CNT_W-1:0]  total_cnt_reg, err_cnt_reg;

    logic push, pop;

    always_comb begin
        dec_level = '0;
        for (int i = 0; i < CODE_W; i++) begin
            dec_level = dec_level + LVL_W'(in_code[i]);
        end
    end

    // A legal code equals the mask with exactly dec_level ones from the LSB.
    generate
        for (genvar gi = 0; gi < CODE_W; gi++) begin : g_mask
            assign therm_mask[gi] = (dec_level > LVL_W'(gi));
        end
    endgenerate

    assign dec_err = (in_code != therm_mask);

    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid_reg && out_ready;

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    // Push+pop together only happens at occupancy 1, so the new entry goes straight to the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_level_reg <= '0;
            head_err_reg   <= 1'b0;
            tail_level_reg <= '0;
            tail_err_reg   <= 1'b0;
            occ_reg        <= 2'd0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_reg == 2'd0) begin
                        head_level_reg <= dec_level;
                        head_err_reg   <= dec_err;
                    end else begin
                        tail_level_reg <= dec_level;
                        tail_err_reg   <= dec_err;
                    end
                end
                2'b01: begin
                    head_level_reg <= tail_level_reg;
                    head_err_reg   <= tail_err_reg;
                end
                2'b11: begin
                    head_level_reg <= dec_level;
                    head_err_reg   <= dec_err;
                end
                default: ;
            endcase
            occ_reg       <= occ_next;
            in_ready_reg  <= (occ_next < 2'd2);
            out_valid_reg <= (occ_next != 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else if (stat_clr) begin
            total_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else if (push) begin
            if (total_cnt_reg != {CNT_W{1'b1}}) total_cnt_reg <= total_cnt_reg + 1'b1;
            if (dec_err && (err_cnt_reg != {CNT_W{1'b1}})) err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

`ifdef DTC_THERM_HIST_EN
    logic [CNT_W-1:0] hist_bin_reg [CODE_W+1];
    logic [CNT_W-1:0] hist_cnt_next;

    generate
        for (genvar gi = 0; gi <= CODE_W; gi++) begin : g_hist
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist_bin_reg[gi] <= '0;
                end else if (stat_clr) begin
                    hist_bin_reg[gi] <= '0;
                end else if (push && (dec_level == LVL_W'(gi)) &&
                             (hist_bin_reg[gi] != {CNT_W{1'b1}})) begin
                    hist_bin_reg[gi] <= hist_bin_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        hist_cnt_next = '0;
        if (hist_sel <= LVL_W'(CODE_W)) hist_cnt_next = hist_bin_reg[hist_sel];
    end

    assign hist_cnt = hist_cnt_next;
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^hist_sel;
    assign hist_cnt        = '0;
`endif

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_level = head_level_reg;
    assign out_err   = head_err_reg;
    assign total_cnt = total_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_dtc_therm_decode_stage.sv
// Directed bench for dtc_therm_decode_stage (CNT_W=4 so saturation is reachable quickly).
module tb_dtc_therm_decode_stage;

    localparam int CODE_W = 8;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CODE_W-1:0] in_code;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_level;
    logic             out_err;
    logic             stat_clr;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       hist_sel;
    logic [CNT_W-1:0] hist_cnt;

    int check_cnt = 0;
    int error_cnt = 0;

    dtc_therm_decode_stage #(.CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_level (out_level),
        .out_err   (out_err),
        .stat_clr  (stat_clr),
        .total_cnt (total_cnt),
        .err_cnt   (err_cnt),
        .hist_sel  (hist_sel),
        .hist_cnt  (hist_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] stream_code [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01, 8'h03};
    int         stream_lvl  [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 2};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
        stat_clr = 1'b0; hist_sel = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_level", out_level, 0);
        check("rst_out_err", out_err, 0);
        check("rst_total", total_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_hist", hist_cnt, 0);

        // Basic and illegal decode, streaming through with out_ready high
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 8'b0001_1111; step();
        check("basic_valid", out_valid, 1);
        check("basic_level", out_level, 5);
        check("basic_err", out_err, 0);
        check("basic_total", total_cnt, 1);
        in_code = 8'b0001_0111; step();
        check("illegal_level", out_level, 4);
        check("illegal_err", out_err, 1);
        check("illegal_err_cnt", err_cnt, 1);
        in_code = 8'h00; step();
        check("zero_level", out_level, 0);
        check("zero_err", out_err, 0);
        in_code = 8'hFF; step();
        check("full_level", out_level, 8);
        check("full_err", out_err, 0);
        check("full_total", total_cnt, 4);
        check("full_err_cnt", err_cnt, 1);
        in_valid = 1'b0; step();
        check("drain_valid", out_valid, 0);

        // Backpressure: third code must wait for a free slot
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 8'h01; step();
        check("bp_ready_after1", in_ready, 1);
        in_code = 8'h03; step();
        check("bp_ready_after2", in_ready, 0);
        in_code = 8'h07; step();
        check("bp_held_ready", in_ready, 0);
        check("bp_head_level", out_level, 1);
        step();
        check("bp_head_hold", out_level, 1);
        check("bp_total_held", total_cnt, 6);
        out_ready = 1'b1; step();
        check("bp_pop1_level", out_level, 2);
        check("bp_pop1_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_third_level", out_level, 3);
        check("bp_third_total", total_cnt, 7);
        step();
        check("bp_empty", out_valid, 0);

        // Streaming ten codes back-to-back
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check("clr_total", total_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_code = stream_code[i]; step();
            check($sformatf("stream%0d_valid", i), out_valid, 1);
            check($sformatf("stream%0d_level", i), out_level, stream_lvl[i]);
        end
        in_valid = 1'b0;
        check("stream_total", total_cnt, 10);
        step();

        // Saturation with 17 illegal accepts
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_code = 8'h17; step();
        end
        in_valid = 1'b0;
        check("sat_total", total_cnt, 15);
        check("sat_err_cnt", err_cnt, 15);
        step();

        // Clear wins over a simultaneous accept, entry still buffered
        in_valid = 1'b1; in_code = 8'h0F; stat_clr = 1'b1; step();
        in_valid = 1'b0; stat_clr = 1'b0;
        check("clracc_total", total_cnt, 0);
        check("clracc_err_cnt", err_cnt, 0);
        check("clracc_valid", out_valid, 1);
        check("clracc_level", out_level, 4);
        step();

        // Histogram
        in_valid = 1'b1; in_code = 8'h0F; step();
        step();
        in_code = 8'h01; step();
        in_valid = 1'b0;
        hist_sel = 4'd4; #1;
`ifdef DTC_THERM_HIST_EN
        check("hist_bin4", hist_cnt, 2);
        hist_sel = 4'd1; #1;
        check("hist_bin1", hist_cnt, 1);
`else
        check("hist_bin4", hist_cnt, 0);
        hist_sel = 4'd1; #1;
        check("hist_bin1", hist_cnt, 0);
`endif
        hist_sel = 4'd9; #1;
        check("hist_bin9", hist_cnt, 0);
        step();

        // Asynchronous reset with a full buffer
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 8'h03; step();
        in_code = 8'h07; step();
        in_valid = 1'b0;
        check("full_before_rst", in_ready, 0);
        check("valid_before_rst", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ready", in_ready, 1);
        check("arst_total", total_cnt, 0);
        check("arst_level", out_level, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
